// File: rtl/jk_target_driver.sv
// rtl/jk_target_driver.sv - drives J/K of an external JK bank toward a target word with settle/verify/retry
module jk_target_driver #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 1,
   parameter int MAX_RETRY     = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] target_data,
   input  logic             target_valid,
   output logic             target_ready,
   input  logic             toggle_mode,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             done,
   output logic             error
);

   localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(1);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             toggle_q, toggle_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic [SW-1:0]    settle_q, settle_d;

   logic [WIDTH-1:0] exc_t;
   logic             exc_tog;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] exc_j;
   logic [WIDTH-1:0] exc_k;

   assign target_ready = (state_q == IDLE);
   assign j_out        = j_q;
   assign k_out        = k_q;
   assign done         = done_q;
   assign error        = error_q;

   // Excitation: in IDLE use the incoming request, otherwise the latched one (retry path)
   always_comb begin
      exc_t   = (state_q == IDLE) ? target_data : target_q;
      exc_tog = (state_q == IDLE) ? toggle_mode : toggle_q;
      diff    = exc_t ^ q_in;
      exc_j   = exc_tog ? diff : (diff & exc_t);
      exc_k   = exc_tog ? diff : (diff & ~exc_t);
   end

   // Next-state and registered-output logic for the IDLE/DRIVE/SETTLE sequence
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      toggle_d = toggle_q;
      j_d      = '0;
      k_d      = '0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      retry_d  = retry_q;
      settle_d = settle_q;
      case (state_q)
         IDLE: begin
            if (target_valid) begin
               target_d = target_data;
               toggle_d = toggle_mode;
               j_d      = exc_j;
               k_d      = exc_k;
               retry_d  = '0;
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            settle_d = SETTLE_LOAD;
            state_d  = SETTLE;
         end
         SETTLE: begin
            if (settle_q > SETTLE_LAST) begin
               settle_d = settle_q - SETTLE_LAST;
            end else if (q_in == target_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + RW'(1);
               j_d     = exc_j;
               k_d     = exc_k;
               state_d = DRIVE;
            end else begin
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset that also cancels a pending done/error
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         target_q <= '0;
         toggle_q <= 1'b0;
         j_q      <= '0;
         k_q      <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         retry_q  <= '0;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         toggle_q <= toggle_d;
         j_q      <= j_d;
         k_q      <= k_d;
         done_q   <= done_d;
         error_q  <= error_d;
         retry_q  <= retry_d;
         settle_q <= settle_d;
      end
   end

endmodule

// File: tb/tb_jk_target_driver.sv
// tb/tb_jk_target_driver.sv - directed self-checking bench for jk_target_driver with a JK bank model
module tb_jk_target_driver;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] target_data = 8'h00;
   logic       target_valid = 1'b0;
   logic       target_ready;
   logic       toggle_mode = 1'b0;
   logic [7:0] q_in;
   logic [7:0] j_out;
   logic [7:0] k_out;
   logic       done;
   logic       error;

   logic [7:0] bank = 8'h00;
   logic [7:0] stuck0 = 8'h00;
   logic       load_req = 1'b0;
   logic [7:0] load_val = 8'h00;

   int tests_run = 0;
   int fails = 0;

   jk_target_driver dut (
      .clock(clock), .reset(reset),
      .target_data(target_data), .target_valid(target_valid), .target_ready(target_ready),
      .toggle_mode(toggle_mode), .q_in(q_in),
      .j_out(j_out), .k_out(k_out), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   assign q_in = bank;

   // JK bank model: hold/set/reset/toggle per bit, with optional stuck-at-0 bits
   always @(posedge clock) begin
      if (load_req) bank <= load_val & ~stuck0;
      else bank <= ((j_out & ~bank) | (~k_out & bank)) & ~stuck0;
   end

   task automatic load_bank(input logic [7:0] v);
      @(negedge clock);
      load_val = v;
      load_req = 1'b1;
      @(negedge clock);
      load_req = 1'b0;
   endtask

   // Present a request for one cycle; returns at the negedge inside the DRIVE cycle
   task automatic send(input logic [7:0] t, input logic tog);
      tests_run++; if (target_ready !== 1'b1) begin fails++; $display("FAIL send_ready actual=%b required=1", target_ready); end
      target_data = t;
      toggle_mode = tog;
      target_valid = 1'b1;
      @(negedge clock);
      target_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      tests_run++; if (target_ready !== 1'b1) begin fails++; $display("FAIL reset_ready actual=%b required=1", target_ready); end
      tests_run++; if (j_out !== 8'h00) begin fails++; $display("FAIL reset_j actual=%h required=00", j_out); end
      tests_run++; if (k_out !== 8'h00) begin fails++; $display("FAIL reset_k actual=%h required=00", k_out); end
      tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done actual=%b required=0", done); end
      tests_run++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error actual=%b required=0", error); end
   endtask

   task automatic test_set_mode();
      load_bank(8'h00);
      send(8'hA5, 1'b0);
      tests_run++; if (j_out !== 8'hA5) begin fails++; $display("FAIL set_j actual=%h required=a5", j_out); end
      tests_run++; if (k_out !== 8'h00) begin fails++; $display("FAIL set_k actual=%h required=00", k_out); end
      @(negedge clock);
      tests_run++; if (j_out !== 8'h00) begin fails++; $display("FAIL set_j_settle actual=%h required=00", j_out); end
      tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL set_done_early actual=%b required=0", done); end
      @(negedge clock);
      tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL set_done actual=%b required=1", done); end
      tests_run++; if (error !== 1'b0) begin fails++; $display("FAIL set_error actual=%b required=0", error); end
      tests_run++; if (target_ready !== 1'b1) begin fails++; $display("FAIL set_ready actual=%b required=1", target_ready); end
      tests_run++; if (bank !== 8'hA5) begin fails++; $display("FAIL set_bank actual=%h required=a5", bank); end
      @(negedge clock);
      tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL set_done_width actual=%b required=0", done); end
   endtask

   task automatic test_toggle_mode();
      load_bank(8'hFF);
      send(8'h0F, 1'b1);
      tests_run++; if (j_out !== 8'hF0) begin fails++; $display("FAIL tog_j actual=%h required=f0", j_out); end
      tests_run++; if (k_out !== 8'hF0) begin fails++; $display("FAIL tog_k actual=%h required=f0", k_out); end
      @(negedge clock);
      tests_run++; if (k_out !== 8'h00) begin fails++; $display("FAIL tog_k_settle actual=%h required=00", k_out); end
      @(negedge clock);
      tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL tog_done actual=%b required=1", done); end
      tests_run++; if (bank !== 8'h0F) begin fails++; $display("FAIL tog_bank actual=%h required=0f", bank); end
   endtask

   task automatic test_retry_error();
      stuck0 = 8'h01;
      load_bank(8'h00);
      send(8'h01, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tests_run++; if (j_out !== ((i % 2 == 0 && i < 8) ? 8'h01 : 8'h00)) begin fails++; $display("FAIL retry_j[%0d] actual=%h required=%h", i, j_out, (i % 2 == 0 && i < 8) ? 8'h01 : 8'h00); end
         tests_run++; if (error !== (i == 8)) begin fails++; $display("FAIL retry_error[%0d] actual=%b required=%b", i, error, i == 8); end
         tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL retry_done[%0d] actual=%b required=0", i, done); end
         @(negedge clock);
      end
      stuck0 = 8'h00;
   endtask

   task automatic test_back_to_back();
      load_bank(8'h00);
      toggle_mode = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 1 || i == 2) begin
            tests_run++; if (target_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_busy[%0d] actual=%b required=0", i, target_ready); end
         end
         if (i == 1) begin
            tests_run++; if (j_out !== 8'h3C || k_out !== 8'h00) begin fails++; $display("FAIL b2b_drive1 actual=%h/%h required=3c/00", j_out, k_out); end
         end
         if (i == 3 || i == 6 || i == 9) begin
            tests_run++; if (done !== 1'b1 || target_ready !== 1'b1) begin fails++; $display("FAIL b2b_done[%0d] actual=%b/%b required=1/1", i, done, target_ready); end
         end
         if (i == 4) begin
            tests_run++; if (j_out !== 8'hC3 || k_out !== 8'h3C) begin fails++; $display("FAIL b2b_drive2 actual=%h/%h required=c3/3c", j_out, k_out); end
         end
         if (i == 7) begin
            tests_run++; if (j_out !== 8'h3C || k_out !== 8'hC3) begin fails++; $display("FAIL b2b_drive3 actual=%h/%h required=3c/c3", j_out, k_out); end
         end
         target_data = (i % 2 == 0) ? 8'h3C : 8'hC3;
         target_valid = (i <= 6);
         @(negedge clock);
      end
      target_valid = 1'b0;
      tests_run++; if (bank !== 8'h3C) begin fails++; $display("FAIL b2b_bank actual=%h required=3c", bank); end
   endtask

   task automatic test_reset_in_settle();
      load_bank(8'h00);
      send(8'h55, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      tests_run++; if (j_out !== 8'h00 || k_out !== 8'h00) begin fails++; $display("FAIL rst_jk actual=%h/%h required=00/00", j_out, k_out); end
      tests_run++; if (done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL rst_pulse actual=%b/%b required=0/0", done, error); end
      tests_run++; if (target_ready !== 1'b1) begin fails++; $display("FAIL rst_ready actual=%b required=1", target_ready); end
      load_bank(8'h00);
      send(8'h55, 1'b0);
      tests_run++; if (j_out !== 8'h55) begin fails++; $display("FAIL rst_redo_j actual=%h required=55", j_out); end
      repeat (2) @(negedge clock);
      tests_run++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL rst_redo_done actual=%b/%b required=1/0", done, error); end
   endtask

   task automatic test_equal_target();
      load_bank(8'h5A);
      send(8'h5A, 1'b0);
      tests_run++; if (j_out !== 8'h00 || k_out !== 8'h00) begin fails++; $display("FAIL eq_jk actual=%h/%h required=00/00", j_out, k_out); end
      tests_run++; if (target_ready !== 1'b0) begin fails++; $display("FAIL eq_busy actual=%b required=0", target_ready); end
      repeat (2) @(negedge clock);
      tests_run++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL eq_done actual=%b/%b required=1/0", done, error); end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_set_mode();
      test_toggle_mode();
      test_retry_error();
      test_back_to_back();
      test_reset_in_settle();
      test_equal_target();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
